// File: rtl/window_generator_fp_if.sv
// Stream bundle between a raster pixel source and the window generator.
// The slave side is the window generator; the master side feeds pixels in
// and consumes windows with their centre coordinates.
interface window_generator_fp_if #(
  parameter int EXP_WIDTH     = 5,
  parameter int FRAC_WIDTH    = 10,
  parameter int WINDOW_WIDTH  = 3,
  parameter int WINDOW_HEIGHT = 3
);
  localparam int FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH;

  logic [FP_WIDTH_REG-1:0]                                   data_i;
  logic                                                      valid_i;
  logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o;
  logic [15:0]                                               col_o;
  logic [15:0]                                               row_o;
  logic                                                      valid_o;

  modport slave (
    input  data_i,
    input  valid_i,
    output window_o,
    output col_o,
    output row_o,
    output valid_o
  );

  modport master (
    output data_i,
    output valid_i,
    input  window_o,
    input  col_o,
    input  row_o,
    input  valid_o
  );
endinterface

// File: rtl/window_generator_fp.sv
// Raster-to-window stage: buffers WINDOW_HEIGHT-1 previous lines and emits a
// WINDOW_HEIGHT x WINDOW_WIDTH window of bit-exact pixels for every position
// where the window lies fully inside the image. One cycle of latency.
module window_generator_fp #(
  parameter int EXP_WIDTH     = 5,
  parameter int FRAC_WIDTH    = 10,
  parameter int WINDOW_WIDTH  = 3,
  parameter int WINDOW_HEIGHT = 3,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  window_generator_fp_if.slave  bus
);

  localparam int FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH;
  localparam int CW           = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW           = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int NLB          = WINDOW_HEIGHT - 1;

  typedef logic [FP_WIDTH_REG-1:0]                         pix_t;
  typedef pix_t [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0]      win_t;

  // Input position of the pixel currently presented
  logic [CW-1:0] in_col_q, in_col_d;
  logic [RW-1:0] in_row_q, in_row_d;

  // Line buffers: buffer k holds the line k+1 above the current one
  pix_t lb_q  [NLB][IMAGE_WIDTH];
  pix_t lb_rd [NLB];

  // Sliding window (internal) and the registered output window
  win_t shift_q, shift_d;
  win_t win_q,   win_d;

  logic        valid_q, valid_d;
  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;
  logic        emit;

  // Read the column of every line buffer at the current input column
  always_comb begin
    for (int k = 0; k < NLB; k++) begin
      lb_rd[k] = lb_q[k][in_col_q];
    end
  end

  // Shift every window row left by one and append the new column on the right
  always_comb begin
    shift_d = shift_q;
    for (int i = 0; i < WINDOW_HEIGHT; i++) begin
      for (int j = 0; j < WINDOW_WIDTH - 1; j++) begin
        shift_d[i][j] = shift_q[i][j+1];
      end
    end
    shift_d[WINDOW_HEIGHT-1][WINDOW_WIDTH-1] = bus.data_i;
    for (int i = 0; i < WINDOW_HEIGHT - 1; i++) begin
      shift_d[i][WINDOW_WIDTH-1] = lb_rd[WINDOW_HEIGHT-2-i];
    end
  end

  // Raster position counters; column wraps into the next row, row wraps into a new frame
  always_comb begin
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    if (bus.valid_i) begin
      if (in_col_q == CW'(IMAGE_WIDTH - 1)) begin
        in_col_d = '0;
        if (in_row_q == RW'(IMAGE_HEIGHT - 1)) begin
          in_row_d = '0;
        end else begin
          in_row_d = in_row_q + RW'(1);
        end
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end
  end

  // A window is complete only once enough columns and rows of this frame have
  // arrived; this also gates out stale right-edge and previous-frame pixels.
  assign emit = bus.valid_i
             && (in_col_q >= CW'(WINDOW_WIDTH - 1))
             && (in_row_q >= RW'(WINDOW_HEIGHT - 1));

  // Output capture: refresh window and centre only on emit, hold otherwise
  always_comb begin
    valid_d = emit;
    win_d   = win_q;
    col_d   = col_q;
    row_d   = row_q;
    if (emit) begin
      win_d = shift_d;
      col_d = 16'(in_col_q) - 16'((WINDOW_WIDTH - 1) / 2);
      row_d = 16'(in_row_q) - 16'((WINDOW_HEIGHT - 1) / 2);
    end
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      in_col_q <= '0;
      in_row_q <= '0;
      valid_q  <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      win_q    <= '0;
    end else begin
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;
      valid_q  <= valid_d;
      col_q    <= col_d;
      row_q    <= row_d;
      win_q    <= win_d;
    end
  end

  // Pixel storage is never reset: stale contents are gated out by emit
  always_ff @(posedge clk_i) begin
    if (bus.valid_i) begin
      shift_q <= shift_d;
      lb_q[0][in_col_q] <= bus.data_i;
      for (int k = 1; k < NLB; k++) begin
        lb_q[k][in_col_q] <= lb_rd[k-1];
      end
    end
  end

  assign bus.window_o = win_q;
  assign bus.col_o    = col_q;
  assign bus.row_o    = row_q;
  assign bus.valid_o  = valid_q;

endmodule

// File: tb/tb_window_generator_fp.sv
// Bench for window_generator_fp on a 5x4 image with a 3x3 window. A reference
// model records each frame as a 2-D image and derives expected windows from it.
module tb_window_generator_fp;

  localparam int EW = 5;
  localparam int FW = 10;
  localparam int WW = 3;
  localparam int WH = 3;
  localparam int IW = 5;
  localparam int IH = 4;

  logic clk;
  logic rst_n;

  window_generator_fp_if #(
    .EXP_WIDTH(EW), .FRAC_WIDTH(FW), .WINDOW_WIDTH(WW), .WINDOW_HEIGHT(WH)
  ) bus ();

  window_generator_fp #(
    .EXP_WIDTH(EW), .FRAC_WIDTH(FW), .WINDOW_WIDTH(WW), .WINDOW_HEIGHT(WH),
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0]             img [0:IH-1][0:IW-1];
  int                      mc, mr;
  int                      nwin;
  logic                    exp_valid;
  logic [2:0][2:0][15:0]   exp_win;
  logic [15:0]             exp_col, exp_row;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mc = 0; mr = 0;
    exp_valid = 1'b0;
    exp_win = '0;
    exp_col = '0;
    exp_row = '0;
  endtask

  // One clock: present inputs, clock them in, then compare against the model
  task automatic step(input logic v, input logic [15:0] d);
    bus.valid_i = v;
    bus.data_i  = d;
    @(posedge clk);
    #1;
    if (v) begin
      img[mr][mc] = d;
      if (mc >= WW - 1 && mr >= WH - 1) begin
        exp_valid = 1'b1;
        for (int i = 0; i < WH; i++)
          for (int j = 0; j < WW; j++)
            exp_win[i][j] = img[mr - (WH - 1) + i][mc - (WW - 1) + j];
        exp_col = 16'(mc - (WW - 1) / 2);
        exp_row = 16'(mr - (WH - 1) / 2);
        nwin++;
      end else begin
        exp_valid = 1'b0;
      end
      mc++;
      if (mc == IW) begin
        mc = 0;
        mr++;
        if (mr == IH) mr = 0;
      end
    end else begin
      exp_valid = 1'b0;
    end
    check("valid_o",  {255'b0, bus.valid_o}, {255'b0, exp_valid});
    check("window_o", 256'(bus.window_o), 256'(exp_win));
    check("col_o",    256'(bus.col_o),    256'(exp_col));
    check("row_o",    256'(bus.row_o),    256'(exp_row));
  endtask

  function automatic logic [143:0] corner_window(input int base);
    logic [2:0][2:0][15:0] f;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        f[i][j] = 16'(base + i * 16 + j);
    return f;
  endfunction

  // Full frame of r*16+c+base, optionally with random idle gaps between pixels
  task automatic send_frame(input int base, input bit gapped);
    logic [47:0] wrap_row;
    nwin = 0;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (gapped) begin
          for (int g = 0; g < 6 && $urandom_range(0, 1) == 1; g++)
            step(1'b0, 16'($urandom));
        end
        step(1'b1, 16'(base + r * 16 + c));
        if (r == 2 && c == 2) begin
          check("first_valid",  {255'b0, bus.valid_o}, {255'b0, 1'b1});
          check("first_window", 256'(bus.window_o), 256'(corner_window(base)));
          check("first_col",    256'(bus.col_o), 256'(16'd1));
          check("first_row",    256'(bus.row_o), 256'(16'd1));
        end
        if (r == 2 && (c == 0 || c == 1)) begin
          check("wrap_suppress", {255'b0, bus.valid_o}, 256'b0);
        end
        if (r == 2 && c == 4) begin
          wrap_row = {16'(base + 'h24), 16'(base + 'h23), 16'(base + 'h22)};
          check("edge_row2", 256'(bus.window_o[2]), 256'(wrap_row));
          check("edge_col",  256'(bus.col_o), 256'(16'd3));
        end
      end
    end
    check("window_count", 256'(nwin), 256'(6));
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check("rst_valid",  {255'b0, bus.valid_o}, 256'b0);
    check("rst_window", 256'(bus.window_o), 256'b0);
    check("rst_col",    256'(bus.col_o), 256'b0);
    check("rst_row",    256'(bus.row_o), 256'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // basic order, then a back-to-back second frame
    send_frame(0, 1'b0);
    send_frame('h100, 1'b0);
    // gapped input
    send_frame(0, 1'b1);

    // partial frame up to pixel (3,2), then asynchronous reset between edges
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < IW; c++)
        if (!(r == 2 && c > 3)) step(1'b1, 16'('h200 + r * 16 + c));
    check("pre_rst_valid", {255'b0, bus.valid_o}, {255'b0, 1'b1});
    bus.valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid",  {255'b0, bus.valid_o}, 256'b0);
    check("arst_window", 256'(bus.window_o), 256'b0);
    check("arst_col",    256'(bus.col_o), 256'b0);
    check("arst_row",    256'(bus.row_o), 256'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(0, 1'b0);
    // a few idle cycles to confirm the outputs hold
    for (int k = 0; k < 4; k++) step(1'b0, 16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_generator_fp.md
# window_generator_fp

Streaming raster-to-window stage that sits directly upstream of the generated `convolution_floating_point` wrappers such as the derivative-kernel wrappers. It accepts one floating-point pixel per cycle in raster order and buffers `WINDOW_HEIGHT-1` previous image lines. For every pixel position where the window lies fully inside the image, it emits one `WINDOW_HEIGHT x WINDOW_WIDTH` window together with the centre pixel's `col`/`row` and a `valid` strobe. Its outputs connect port-for-port to the `window_i`/`col_i`/`row_i`/`valid_i` inputs of the convolution wrappers.

## Interface
- `EXP_WIDTH`, 5, exponent bits.
- `FRAC_WIDTH`, 10, fraction bits.
- `WINDOW_WIDTH`, 3, window columns; odd, ≥3.
- `WINDOW_HEIGHT`, 3, window rows; odd, ≥3.
- `IMAGE_WIDTH`, 640, pixels per line; ≥`WINDOW_WIDTH`.
- `IMAGE_HEIGHT`, 480, lines per frame; ≥`WINDOW_HEIGHT`.
- `FP_WIDTH_REG`, `1+FRAC_WIDTH+EXP_WIDTH`, local: pixel width.

Ports:
- `clk_i`  in  1  sole clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `data_i`  in  `FP_WIDTH_REG`  pixel, raster order, top-left first.
- `valid_i`  in  1  `data_i` is accepted this cycle. There is no backpressure.
- `window_o`  out  `[WINDOW_HEIGHT][WINDOW_WIDTH] x FP_WIDTH_REG`  pixel window.
  - `[0]` is the top (oldest) line.
  - `[i][0]` is the leftmost column.
- `col_o`  out  16  column of the window centre pixel.
- `row_o`  out  16  row of the window centre pixel.
- `valid_o`  out  1  window/col/row valid this cycle.

## Operation
- **Input position counters.** Internal `in_col`/`in_row` give the position of the pixel currently presented.
  - Both counters advance only on `valid_i`.
  - `in_col` wraps at `IMAGE_WIDTH-1` to 0, and `in_row` increments at the same time.
  - `in_row` wraps at `IMAGE_HEIGHT-1` to 0, so the next pixel starts a new frame.
  - No frame-start input exists: frame alignment is set by reset only.
- **Line buffers.** `WINDOW_HEIGHT-1` line buffers, each `IMAGE_WIDTH` deep, are implemented as RAM or shift arrays.
  - On each accepted pixel, each buffer outputs the pixel at the same column from one line earlier than its input.
  - The new pixel is written at `in_col`.
- **Window shift register.** The register is `WINDOW_HEIGHT x WINDOW_WIDTH`.
  - On each accepted pixel, every row shifts left by one column.
  - The new rightmost column is filled with `[H-1]` = `data_i`, `[H-2]` = line buffer 0 output, and so on upward to `[0]` = oldest line.
  - Contents do not change without `valid_i`.
- **Output rule.** When pixel (c, r) is accepted with `c ≥ WINDOW_WIDTH-1` and `r ≥ WINDOW_HEIGHT-1`, the next cycle has:
  - `valid_o` = 1.
  - `window_o[i][j]` = pixel(`r-(WINDOW_HEIGHT-1)+i`, `c-(WINDOW_WIDTH-1)+j`).
  - `col_o` = `c-(WINDOW_WIDTH-1)/2`.
  - `row_o` = `r-(WINDOW_HEIGHT-1)/2`.
- **Suppressed positions.** Every other accepted pixel, and every cycle without `valid_i`, gives `valid_o` = 0.
  - Windows that straddle a line wrap (stale right-edge pixels from the previous line) are never flagged valid.
- **Output hold.** `window_o`, `col_o` and `row_o` hold their last values while `valid_o` = 0.
- **Window count.** Each frame emits exactly `(IMAGE_WIDTH-WINDOW_WIDTH+1)*(IMAGE_HEIGHT-WINDOW_HEIGHT+1)` valid windows.
- **Values.** Pixel values are passed bit-exact; no floating-point arithmetic is performed.
  - `col_o`/`row_o` are zero-extended to 16 bits.

## Timing
- **Latency.** Exactly 1 cycle from the accepting `valid_i` edge to `valid_o`; outputs are registered.
- **Throughput.** One window per cycle sustained with `valid_i` held high.
  - Arbitrary `valid_i` gaps are allowed, including within a line and across line or frame boundaries.
  - Gaps have no effect on the data.
- **Reset (`rst_i` = 0, asynchronous).** Takes effect immediately, independent of `clk_i`:
  - `valid_o` = 0, `col_o` = 0, `row_o` = 0.
  - `window_o` = all zeros.
  - `in_col` = 0, `in_row` = 0.
- **Reset behaviour.**
  - Line buffer contents are not reset; they are don't-care because of output gating.
  - The first accepted pixel after reset release is (0, 0).
  - Reset mid-frame discards the partial frame, and no valid window is produced from pre-reset pixels.
- **Frame wrap.** Back-to-back frames need no idle cycles.
  - The first `WINDOW_HEIGHT-1` lines of each frame produce no output, because the buffered previous-frame lines are gated out.

## Test plan
- **Basic order, 3x3 on a 5x4 image.** Feed raw pixel value `r*16+c` continuously.
  - The first `valid_o` comes the cycle after pixel (2, 2).
  - That output has `window_o[0]` = {0x00, 0x01, 0x02}, `[1]` = {0x10, 0x11, 0x12}, `[2]` = {0x20, 0x21, 0x22}, `col_o` = 1, `row_o` = 1.
  - Exactly 6 valid windows appear per frame, with centres (1..3, 1..2).
- **Line-wrap suppression, same image.** No `valid_o` follows pixels (0, 2) or (1, 2).
  - The window after (4, 2) has `window_o[2]` = {0x22, 0x23, 0x24} and `col_o` = 3.
- **Gapped input.** Repeat the basic-order test with `valid_i` pseudo-randomly low 50% of cycles.
  - The sequence of valid windows is identical, and each appears exactly 1 cycle after its accepting pixel.
  - Outputs hold steady during gaps.
- **Back-to-back frames.** Send 2 frames with different values (frame 2 = `0x100 + r*16+c`).
  - Frame 2 produces 6 windows, the first being `window_o[0][0]` = 0x100 at centre (1, 1).
  - No window mixes frame 1 and frame 2 pixels.
- **Asynchronous reset mid-frame.** Assert `rst_i` = 0 between clock edges after pixel (3, 2).
  - `valid_o`, `col_o`, `row_o` and `window_o` read 0 before the next edge.
  - After release, a full frame reproduces the basic-order results exactly.
- **Downstream integration.** Connect to a `dy_0_fp16` instance and feed fp16 pixel values equal to the row index, giving a vertical ramp.
  - Every output equals fp16 2.0 (0x4000): centre pixel (r+1) − (r−1) = 2.
